// File: rtl/midi_note_decoder.sv
// midi_note_decoder: turns the raw MIDI byte stream from the UART receiver into
// single-cycle note-change events for the polyphony dispatcher. Tracks running
// status, maps Note On with velocity 0 to Note Off, skips non-note messages
// byte-accurately and ignores interleaved system real-time bytes.
//
// Optional feature: define MIDI_CHANNEL_FILTER_EN to decode notes only on CHANNEL;
// note messages on other channels are then skipped like 3-byte channel messages.
//
// Ports:
//   clock_50_000_000      system clock, rising edge
//   reset                 asynchronous active-high reset
//   midi_byte             received byte, valid while midi_byte_ready is high
//   midi_byte_ready       one-cycle strobe per received byte
//   note                  {status(1=ON), note_number[6:0], velocity[6:0]}, held
//   note_ready            one-cycle pulse marking a new note
//   running_status_valid  high while a note running status is latched
module midi_note_decoder #(
  parameter int unsigned CHANNEL = 0
) (
  input  logic        clock_50_000_000,
  input  logic        reset,
  input  logic [7:0]  midi_byte,
  input  logic        midi_byte_ready,
  output logic [14:0] note,
  output logic        note_ready,
  output logic        running_status_valid
);

  typedef struct packed {
    logic       status;       // 1 = ON, 0 = OFF
    logic [6:0] note_number;
    logic [6:0] velocity;
  } note_change_t;

  typedef enum logic [2:0] {
    StIdle,
    StNoteD1,
    StNoteD2,
    StSkipD1,
    StSkipD2,
    StSkipSys
  } state_e;

  state_e       state_q, state_d;
  logic         kind_on_q, kind_on_d;     // latched note kind: 1 = Note On
  logic         skip_two_q, skip_two_d;   // skipped message carries two data bytes
  logic [6:0]   note_num_q, note_num_d;
  note_change_t note_q, note_d;
  logic         note_ready_q, note_ready_d;
  logic         rs_valid_q, rs_valid_d;

  logic is_status, is_realtime, is_syscommon, chan_ok;

  assign is_status    = midi_byte[7];
  assign is_realtime  = (midi_byte[7:3] == 5'b11111);
  assign is_syscommon = (midi_byte[7:3] == 5'b11110);

`ifdef MIDI_CHANNEL_FILTER_EN
  assign chan_ok = (midi_byte[3:0] == 4'(CHANNEL));
`else
  logic [3:0] unused_channel;
  assign unused_channel = 4'(CHANNEL);
  assign chan_ok        = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    kind_on_d    = kind_on_q;
    skip_two_d   = skip_two_q;
    note_num_d   = note_num_q;
    note_d       = note_q;
    note_ready_d = 1'b0;
    rs_valid_d   = rs_valid_q;

    if (midi_byte_ready) begin
      if (is_realtime) begin
        // Real-time bytes are transparent to the parse.
      end else if (is_syscommon) begin
        state_d    = StSkipSys;
        rs_valid_d = 1'b0;
      end else if (is_status) begin
        // Any channel status aborts a partial message.
        case (midi_byte[6:4])
          3'h0, 3'h1: begin
            if (chan_ok) begin
              state_d    = StNoteD1;
              kind_on_d  = midi_byte[4];
              rs_valid_d = 1'b1;
            end else begin
              state_d    = StSkipD2;
              skip_two_d = 1'b1;
              rs_valid_d = 1'b0;
            end
          end
          3'h4, 3'h5: begin
            state_d    = StSkipD1;
            skip_two_d = 1'b0;
            rs_valid_d = 1'b0;
          end
          default: begin
            state_d    = StSkipD2;
            skip_two_d = 1'b1;
            rs_valid_d = 1'b0;
          end
        endcase
      end else begin
        case (state_q)
          StNoteD1: begin
            note_num_d = midi_byte[6:0];
            state_d    = StNoteD2;
          end
          StNoteD2: begin
            note_d.status      = kind_on_q && (midi_byte[6:0] != 7'd0);
            note_d.note_number = note_num_q;
            note_d.velocity    = midi_byte[6:0];
            note_ready_d       = 1'b1;
            state_d            = StNoteD1;
          end
          // Running status on skipped messages: wrap back to the first data byte.
          StSkipD1: state_d = skip_two_q ? StSkipD2 : StSkipD1;
          StSkipD2: state_d = StSkipD1;
          default:  state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      kind_on_q    <= 1'b0;
      skip_two_q   <= 1'b0;
      note_num_q   <= 7'd0;
      note_q       <= '0;
      note_ready_q <= 1'b0;
      rs_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_on_q    <= kind_on_d;
      skip_two_q   <= skip_two_d;
      note_num_q   <= note_num_d;
      note_q       <= note_d;
      note_ready_q <= note_ready_d;
      rs_valid_q   <= rs_valid_d;
    end
  end

  assign note                 = note_q;
  assign note_ready           = note_ready_q;
  assign running_status_valid = rs_valid_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
module tb_midi_note_decoder;

  localparam int unsigned TbChannel = 2;
`ifdef MIDI_CHANNEL_FILTER_EN
  localparam bit FilterEn = 1'b1;
`else
  localparam bit FilterEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  midi_byte;
  logic        midi_byte_ready;
  logic [14:0] note;
  logic        note_ready;
  logic        running_status_valid;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  midi_note_decoder #(.CHANNEL(TbChannel)) dut (
    .clock_50_000_000     (clk),
    .reset                (reset),
    .midi_byte            (midi_byte),
    .midi_byte_ready      (midi_byte_ready),
    .note                 (note),
    .note_ready           (note_ready),
    .running_status_valid (running_status_valid)
  );

  // Behavioural reference: current status byte plus the data bytes collected so far.
  int          m_status;      // -1 when no status is in force
  bit          m_is_note;
  logic [6:0]  m_data[$];
  logic        m_ready;
  logic [14:0] m_note;
  logic        m_rs;

  function automatic int msg_len(input int st);
    case (st >> 4)
      8, 9, 10, 11, 14: return 2;
      12, 13:           return 1;
      default:          return 0;  // system common: discard until next status
    endcase
  endfunction

  function automatic void model_reset();
    m_status = -1;
    m_is_note = 1'b0;
    m_data.delete();
    m_ready = 1'b0;
    m_note = '0;
    m_rs = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input logic rdy);
    m_ready = 1'b0;
    if (!rdy || b >= 8'hF8) return;
    if (b >= 8'h80) begin
      m_status = int'(b);
      m_data.delete();
      m_is_note = (b < 8'hA0) && (!FilterEn || (int'(b) % 16) == int'(TbChannel));
      m_rs = m_is_note;
      return;
    end
    if (m_status < 0 || msg_len(m_status) == 0) return;
    m_data.push_back(b[6:0]);
    if (m_data.size() == msg_len(m_status)) begin
      if (m_is_note) begin
        m_ready = 1'b1;
        m_note = {(m_status >= 8'h90) && (m_data[1] != 0), m_data[0], m_data[1]};
      end
      m_data.delete();
    end
  endfunction

  function automatic void check(input string name, input logic [14:0] act,
                                input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [14:0] ev(input bit on, input int n, input int v);
    return {on, 7'(n), 7'(v)};
  endfunction

  task automatic step(input logic [7:0] b, input logic rdy);
    @(negedge clk);
    midi_byte = b;
    midi_byte_ready = rdy;
    model_byte(b, rdy);
    @(posedge clk);
    #1;
    midi_byte_ready = 1'b0;
  endtask

  task automatic step_model(input logic [7:0] b, input logic rdy, input string name);
    step(b, rdy);
    check({name, ".ready"}, 15'(note_ready), 15'(m_ready));
    check({name, ".rs"}, 15'(running_status_valid), 15'(m_rs));
    check({name, ".note"}, note, m_note);
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check({name, ".rst_note"}, note, 15'd0);
    check({name, ".rst_ready"}, 15'(note_ready), 15'd0);
    check({name, ".rst_rs"}, 15'(running_status_valid), 15'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [7:0]  b;
    logic        rdy;
    logic        exp_ready;
    logic [14:0] exp_note;
    logic        exp_rs;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] b, input logic rdy, input logic er,
                              input logic [14:0] en, input logic ers);
    vec_t v;
    v.b = b; v.rdy = rdy; v.exp_ready = er; v.exp_note = en; v.exp_rs = ers;
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1'b1;
    midi_byte = 8'h00;
    midi_byte_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset.note", note, 15'd0);
    check("reset.ready", 15'(note_ready), 15'd0);
    check("reset.rs", 15'(running_status_valid), 15'd0);

    // Directed vectors, all note traffic on channel 2 so both builds decode it.
    add(8'h92, 1, 0, 0, 1); add(8'h3C, 1, 0, 0, 1); add(8'h64, 1, 1, ev(1, 60, 100), 1);
    add(8'h40, 1, 0, 0, 1); add(8'h50, 1, 1, ev(1, 64, 80), 1);
    add(8'h3C, 1, 0, 0, 1); add(8'h00, 1, 1, ev(0, 60, 0), 1);
    add(8'h82, 1, 0, 0, 1); add(8'hF8, 1, 0, 0, 1); add(8'h3C, 1, 0, 0, 1);
    add(8'hFE, 1, 0, 0, 1); add(8'h20, 1, 1, ev(0, 60, 32), 1);
    add(8'hB2, 1, 0, 0, 0); add(8'h07, 1, 0, 0, 0); add(8'h7F, 1, 0, 0, 0);
    add(8'h3C, 1, 0, 0, 0);
    add(8'h92, 1, 0, 0, 1); add(8'h3C, 1, 0, 0, 1); add(8'hF0, 1, 0, 0, 0);
    add(8'h01, 1, 0, 0, 0); add(8'h02, 1, 0, 0, 0); add(8'h3C, 1, 0, 0, 0);
    add(8'h64, 1, 0, 0, 0);
    add(8'h92, 1, 0, 0, 1); add(8'h3C, 1, 0, 0, 1); add(8'h82, 1, 0, 0, 1);
    add(8'h3C, 1, 0, 0, 1); add(8'h40, 1, 1, ev(0, 60, 64), 1);
    add(8'hC2, 1, 0, 0, 0); add(8'h10, 1, 0, 0, 0); add(8'h20, 1, 0, 0, 0);
    add(8'h30, 1, 0, 0, 0);
    add(8'h92, 1, 0, 0, 1); add(8'h3C, 1, 0, 0, 1); add(8'h64, 0, 0, 0, 1);
    add(8'h7F, 1, 1, ev(1, 60, 127), 1);
    add(8'hE2, 1, 0, 0, 0); add(8'h01, 1, 0, 0, 0); add(8'h02, 1, 0, 0, 0);
    add(8'h03, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].b, vecs[i].rdy);
      check($sformatf("vec%0d.ready", i), 15'(note_ready), 15'(vecs[i].exp_ready));
      check($sformatf("vec%0d.rs", i), 15'(running_status_valid), 15'(vecs[i].exp_rs));
      if (vecs[i].exp_ready) check($sformatf("vec%0d.note", i), note, vecs[i].exp_note);
    end

    // Reset between the note number and the velocity: nothing may be emitted.
    step_model(8'h92, 1, "rstmid0");
    step_model(8'h3C, 1, "rstmid1");
    async_reset("rstmid");
    step_model(8'h3C, 1, "rstmid2");
    step_model(8'h64, 1, "rstmid3");

    // Other-channel note: decoded without the filter, skipped with it.
    step_model(8'h91, 1, "chan0");
    step_model(8'h3C, 1, "chan1");
    step_model(8'h64, 1, "chan2");
    step_model(8'h92, 1, "chan3");
    step_model(8'h3C, 1, "chan4");
    step_model(8'h64, 1, "chan5");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] b;
      logic       rdy;
      int         r;
      r = int'($urandom_range(0, 99));
      rdy = 1'b1;
      if (r < 45)      b = 8'($urandom_range(0, 127));
      else if (r < 60) b = 8'h80 | 8'($urandom_range(0, 1) << 4) |
                           8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : TbChannel);
      else if (r < 70) b = 8'($urandom_range(8'hA0, 8'hEF));
      else if (r < 74) b = 8'($urandom_range(8'hF0, 8'hF7));
      else if (r < 84) b = 8'($urandom_range(8'hF8, 8'hFF));
      else begin
        b = 8'($urandom_range(0, 255));
        rdy = 1'b0;
      end
      if ($urandom_range(0, 499) == 0) async_reset("rnd");
      step_model(b, rdy, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_note_decoder.md
# midi_note_decoder

Parses the raw MIDI byte stream from the UART receiver into single-cycle note-change events for the polyphony dispatcher. It tracks running status, turns Note On with velocity 0 into Note Off, and skips every non-note message byte-accurately. System real-time bytes may be interleaved anywhere without disturbing the parse. It sits between the UART byte receiver and the dispatcher; its output has the same `note_change_t` / ready-pulse form the dispatcher consumes.

## Interface

- `CHANNEL`, default 0: MIDI channel (0-15) accepted when channel filtering is compiled in; ignored otherwise.
- `clock_50_000_000`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `midi_byte`  input  8  received byte; valid only while `midi_byte_ready` is high.
- `midi_byte_ready`  input  1  one-cycle strobe per received byte; may be high on consecutive cycles.
- `note`  output  `$bits(note_change_t)`  decoded event: `status` (ON/OFF), `note_number` (7 b), `velocity` (7 b); held until the next event.
- `note_ready`  output  1  one-cycle pulse marking a new `note`.
- `running_status_valid`  output  1  high while a note running status is latched (debug/visibility).

## Operation

- Byte classes:
  - status: bit7 = 1;
  - real-time: 0xF8-0xFF;
  - system common: 0xF0-0xF7;
  - data: bit7 = 0.
- State machine states:
  - `IDLE`: no running status.
  - `NOTE_D1`, `NOTE_D2`: note message, awaiting data byte 1 or data byte 2.
  - `SKIP_D1`, `SKIP_D2`: non-note channel message, awaiting data byte 1 or data byte 2.
  - `SKIP_SYS`: system common message in progress.
- Real-time byte: no effect on any state, register or output, in every state.
- Channel status byte (0x80-0xEF), accepted in any state, aborts any partial message:
  - 0x8n / 0x9n: latch kind (OFF or ON) and channel, go to `NOTE_D1`, set `running_status_valid`.
  - 0xCn / 0xDn: go to `SKIP_D1`, clear `running_status_valid`.
  - 0xAn / 0xBn / 0xEn: go to `SKIP_D2`, clear `running_status_valid`.
- System common byte (0xF0-0xF7): go to `SKIP_SYS`, clear running status. Data bytes are discarded until the next status byte.
- Data byte handling:
  - `IDLE`: discarded.
  - `NOTE_D1`: latch note number, go to `NOTE_D2`.
  - `NOTE_D2`: emit the event, return to `NOTE_D1` (running status).
  - `SKIP_D2` -> `SKIP_D1` -> `SKIP_D2`, or `SKIP_D1` -> `SKIP_D1`, per the latched message length; nothing is emitted.
- Event formation:
  - `status` = ON only if the kind is ON and velocity ≠ 0; otherwise OFF.
  - `velocity` = received byte[6:0] (kept as received, including 0).
  - `note_number` = latched byte[6:0].

## Timing

- Reset values:
  - `note` all-zero (status OFF, number 0, velocity 0);
  - `note_ready` 0;
  - `running_status_valid` 0;
  - state `IDLE`.
- Latency: `note_ready` is high in the cycle after the edge that samples the final data byte with `midi_byte_ready` = 1. `note` updates on that same edge.
- `note_ready` is never high for two consecutive cycles unless two final data bytes arrive on consecutive cycles; each pulse corresponds to exactly one event.
- No backpressure: the dispatcher must accept an event in any cycle.
- Reset asserted mid-message: state and outputs go to reset values immediately. The next data bytes are discarded until a status byte arrives.
- Status byte arriving in `NOTE_D2`: the partial note is dropped and no event is emitted.

## Configuration

- `MIDI_CHANNEL_FILTER_EN` defined:
  - 0x8n/0x9n with n ≠ `CHANNEL` is treated like 0xAn: it enters `SKIP_D2` and clears running status.
  - Matching channels decode normally.
- `MIDI_CHANNEL_FILTER_EN` undefined: all 16 channels decode and `CHANNEL` has no effect.

## Test plan

- Reset, then 0x90 0x3C 0x64 -> one `note_ready` pulse, note = {ON, 60, 100}, one cycle after the 0x64 strobe.
- Running status: 0x90 0x3C 0x64 0x40 0x50 0x3C 0x00 -> three events: {ON,60,100}, {ON,64,80}, {OFF,60,0}.
- Interleaved real time: 0x80 0xF8 0x3C 0xFE 0x20 -> single {OFF,60,32}; `running_status_valid` stays 1 throughout.
- Skip/abort: 0xB0 0x07 0x7F 0x3C, then 0x90 0x3C, then 0xF0 0x01 0x02 -> zero events; `running_status_valid` is 0 after 0xB0 and after 0xF0.
- Reset pulse asserted between 0x90 0x3C and 0x64 -> no event; outputs at reset values; a following 0x3C 0x64 gives no event.
- With `MIDI_CHANNEL_FILTER_EN` and `CHANNEL` = 2: 0x91 0x3C 0x64 gives no event; 0x92 0x3C 0x64 gives {ON,60,100}.
